mem_port_arbiter: RTL

//  Shares the single-port data/instruction memory between two requesters: the CPU (fetch and lw/sw,

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the CPU and an
// external port (UART loader / debug DMA). The CPU has fixed priority, and a
// starvation counter forces an ext grant after STARVE_MAX CPU grants.
// Ports: clk, reset (sync, active-low); cpu_req/we/addr/wdata in,
//   cpu_ack/rdata/stall out; ext_req/we/addr/wdata in, ext_ack/rdata out;
//   mem_en/we/addr/wdata out, mem_rdata in.
// Option: ARB_LOCK_EN adds input ext_lock, which keeps ext owning the memory
//   across back-to-back accesses while it stays high.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
`ifdef ARB_LOCK_EN
  input  logic              ext_lock,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_CPU,
    BUSY_EXT
  } state_t;

  localparam logic [3:0] LAT  = 4'(MEM_LAT);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] wcnt;
  logic [3:0] scnt;
  logic       op_we;
  logic       cpu_v;
  logic       ext_v;
  logic       ext_win;
  logic       cpu_win;
  logic       locked;

`ifdef ARB_LOCK_EN
  logic lock_q;
  assign locked = lock_q;
`else
  assign locked = 1'b0;
`endif

  // A requester still showing its ack is
  // holding req for the access just done.
  assign cpu_v = cpu_req & ~cpu_ack;
  assign ext_v = ext_req & ~ext_ack;

  assign ext_win = (state == IDLE) & ext_v
                 & (~cpu_v | (scnt == SMAX)
                    | locked);
  assign cpu_win = (state == IDLE) & cpu_v
                 & ~ext_win;

  assign cpu_stall = cpu_req & ~cpu_ack;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      scnt      <= '0;
      op_we     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      ext_ack   <= 1'b0;
      cpu_rdata <= '0;
      ext_rdata <= '0;
`ifdef ARB_LOCK_EN
      lock_q    <= 1'b0;
`endif
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            ext_win: begin
              state     <= BUSY_EXT;
              mem_en    <= 1'b1;
              mem_we    <= ext_we;
              op_we     <= ext_we;
              mem_addr  <= ext_addr;
              mem_wdata <= ext_wdata;
              wcnt      <= LAT;
            end
            cpu_win: begin
              state     <= BUSY_CPU;
              mem_en    <= 1'b1;
              mem_we    <= cpu_we;
              op_we     <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              wcnt      <= LAT;
            end
            default: ;
          endcase
        end
        BUSY_CPU, BUSY_EXT: begin
          // The ack cycle closes the access;
          // arbitration resumes after it.
          if (cpu_ack | ext_ack) begin
            cpu_ack <= 1'b0;
            ext_ack <= 1'b0;
            state   <= IDLE;
          end else if (wcnt == 4'd0) begin
            if (state == BUSY_CPU) begin
              cpu_ack <= 1'b1;
              if (!op_we)
                cpu_rdata <= mem_rdata;
            end else begin
              ext_ack <= 1'b1;
              if (!op_we)
                ext_rdata <= mem_rdata;
            end
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // scnt counts CPU grants made
      // over a waiting ext request.
      if (!ext_req)
        scnt <= '0;
      else if (!locked) begin
        if (ext_win)
          scnt <= '0;
        else if (cpu_win && scnt != SMAX)
          scnt <= scnt + 4'd1;
      end

`ifdef ARB_LOCK_EN
      if (!ext_lock)
        lock_q <= 1'b0;
      else if (ext_ack)
        lock_q <= 1'b1;
`endif
    end
  end

endmodule
